clk_run_ctrl: RTL

CLK_RUN_CTRL -- requirements
Module: clk_run_ctrl

---
 rtl/clk_ctrl_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/clk_run_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU run/step clock controller: FSM state codes,
// speed-level geometry and the saturating level-update rule.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  localparam int NUM_LEVELS = 7;
  localparam int LEVEL_W    = 3;
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  // Opposing requests in the same cycle cancel; both ends saturate.
  function automatic logic [LEVEL_W-1:0] next_level(
    input logic [LEVEL_W-1:0] lvl,
    input logic               up,
    input logic               dn
  );
    next_level = lvl;
    if (up && !dn && lvl != MAX_LEVEL) begin
      next_level = lvl + LEVEL_W'(1);
    end else if (dn && !up && lvl != '0) begin
      next_level = lvl - LEVEL_W'(1);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stability-count debouncer and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_db);
  assign w_accept  = w_differs && (r_cnt == LAST_CNT);

  // NOTE: non-blocking assignments so every flop here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_db <= r_sync2;
      end
      r_press <= w_accept && r_sync2;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clk_run_ctrl.sv
// Run/pause/single-step controller producing a clock-enable pulse for a CPU
// at one of seven button-selectable speeds, with a sticky halt.
module clk_run_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LEVEL_0_INDEX   = 49_999_999,
  parameter int unsigned LEVEL_1_INDEX   = 12_499_999,
  parameter int unsigned LEVEL_2_INDEX   = 3_124_999,
  parameter int unsigned LEVEL_3_INDEX   = 1_562_499,
  parameter int unsigned LEVEL_4_INDEX   = 781_249,
  parameter int unsigned LEVEL_5_INDEX   = 390_624,
  parameter int unsigned LEVEL_6_INDEX   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_run,
  input  logic               btn_step,
  input  logic               btn_faster,
  input  logic               btn_slower,
  input  logic               halt,
  output logic               cpu_ce,
  output logic [1:0]         run_state,
  output logic [LEVEL_W-1:0] curr_level
);

  logic               w_run_ev;
  logic               w_step_ev;
  logic               w_fast_ev;
  logic               w_slow_ev;
  run_state_e         r_state;
  run_state_e         w_state_next;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_next;
  logic               w_level_chg;
  logic [31:0]        r_tick;
  logic [31:0]        w_index;
  logic               w_tc;
  logic               w_ce_next;
  logic               r_cpu_ce;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_run), .o_press(w_run_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_step), .o_press(w_step_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_faster (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_faster), .o_press(w_fast_ev)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slower (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_slower), .o_press(w_slow_ev)
  );

  assign w_level_next = next_level(r_level, w_fast_ev, w_slow_ev);
  assign w_level_chg  = (w_level_next != r_level);

  always_comb begin
    w_index = LEVEL_6_INDEX;
    case (r_level)
      3'd0:    w_index = LEVEL_0_INDEX;
      3'd1:    w_index = LEVEL_1_INDEX;
      3'd2:    w_index = LEVEL_2_INDEX;
      3'd3:    w_index = LEVEL_3_INDEX;
      3'd4:    w_index = LEVEL_4_INDEX;
      3'd5:    w_index = LEVEL_5_INDEX;
      default: w_index = LEVEL_6_INDEX;
    endcase
  end

  assign w_tc = (r_state == ST_RUN) && (r_tick == w_index);

  // NOTE: defaults first, so no branch of this block can leave a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PAUSE: begin
        if (w_run_ev)       w_state_next = ST_RUN;
        else if (w_step_ev) w_state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt)          w_state_next = ST_HALTED;
        else if (w_run_ev) w_state_next = ST_PAUSE;
      end
      ST_STEP:   w_state_next = halt ? ST_HALTED : ST_PAUSE;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_PAUSE;
    endcase
    // Gating on the next state keeps a terminal-count pulse out of PAUSE/HALTED.
    w_ce_next = (w_state_next == ST_STEP) ||
                ((w_state_next == ST_RUN) && w_tc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_PAUSE;
      r_level  <= '0;
      r_tick   <= '0;
      r_cpu_ce <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_level  <= w_level_next;
      r_cpu_ce <= w_ce_next;
      if (w_level_chg || w_tc ||
          ((r_state == ST_PAUSE) && (w_state_next == ST_RUN))) begin
        r_tick <= '0;
      end else if (r_state == ST_RUN) begin
        r_tick <= r_tick + 32'd1;
      end
    end
  end

  assign cpu_ce     = r_cpu_ce;
  assign run_state  = r_state;
  assign curr_level = r_level;

endmodule
